// File: rtl/ascii_operand_capture_if.sv
// Character input and captured-operand output bundle for ascii_operand_capture.
// The slave modport faces the capture block; the master modport faces whatever feeds it characters.
interface ascii_operand_capture_if;
    logic [6:0] char_in;
    logic       char_valid;
    logic [6:0] AD_A;
    logic [6:0] AU_A;
    logic [6:0] AD_B;
    logic [6:0] AU_B;
    logic       operands_valid;
    logic       err;
    logic [1:0] state;

    modport slave (
        input  char_in,
        input  char_valid,
        output AD_A,
        output AU_A,
        output AD_B,
        output AU_B,
        output operands_valid,
        output err,
        output state
    );

    modport master (
        output char_in,
        output char_valid,
        input  AD_A,
        input  AU_A,
        input  AD_B,
        input  AU_B,
        input  operands_valid,
        input  err,
        input  state
    );
endinterface

// File: rtl/ascii_operand_capture.sv
// Captures two 0-99 ASCII operands typed as "<A>+<B>=" and presents them right-aligned.
// Optional feature: define BACKSPACE_EN to make 0x08 delete the last digit of the current operand.
module ascii_operand_capture (
    input  logic                          clk,
    input  logic                          rst_n,
    ascii_operand_capture_if.slave        bus
);
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [6:0] C_ZERO = 7'h30;
    localparam logic [6:0] C_NINE = 7'h39;
    localparam logic [6:0] C_PLUS = 7'h2B;
    localparam logic [6:0] C_EQ   = 7'h3D;
`ifdef BACKSPACE_EN
    localparam logic [6:0] C_BS   = 7'h08;
`endif

    state_t     r_state, w_state;
    logic [6:0] r_ad_a, w_ad_a, r_au_a, w_au_a;
    logic [6:0] r_ad_b, w_ad_b, r_au_b, w_au_b;
    logic [1:0] r_cnt_a, w_cnt_a, r_cnt_b, w_cnt_b;
    logic       r_err, w_err;
    logic       r_valid, w_valid;
    logic       w_is_digit;

    assign w_is_digit = (bus.char_in >= C_ZERO) && (bus.char_in <= C_NINE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_A;
            r_ad_a  <= C_ZERO;
            r_au_a  <= C_ZERO;
            r_ad_b  <= C_ZERO;
            r_au_b  <= C_ZERO;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ad_a  <= w_ad_a;
            r_au_a  <= w_au_a;
            r_ad_b  <= w_ad_b;
            r_au_b  <= w_au_b;
            r_cnt_a <= w_cnt_a;
            r_cnt_b <= w_cnt_b;
            r_err   <= w_err;
            r_valid <= w_valid;
        end
    end

    always_comb begin
        w_state = r_state;
        w_ad_a  = r_ad_a;
        w_au_a  = r_au_a;
        w_ad_b  = r_ad_b;
        w_au_b  = r_au_b;
        w_cnt_a = r_cnt_a;
        w_cnt_b = r_cnt_b;
        w_err   = r_err;
        w_valid = 1'b0;  // pulse lasts only the cycle after '=' is accepted

        if (bus.char_valid) begin
            unique case (r_state)
                S_A: begin
                    if (w_is_digit) begin
                        if (r_cnt_a < 2'd2) begin
                            w_ad_a  = r_au_a;
                            w_au_a  = bus.char_in;
                            w_cnt_a = r_cnt_a + 2'd1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else if (bus.char_in == C_PLUS) begin
                        if (r_cnt_a != 2'd0) w_state = S_B;
                        else                 w_err   = 1'b1;
                    end
`ifdef BACKSPACE_EN
                    else if (bus.char_in == C_BS) begin
                        if (r_cnt_a != 2'd0) begin
                            w_au_a  = r_ad_a;
                            w_ad_a  = C_ZERO;
                            w_cnt_a = r_cnt_a - 2'd1;
                        end
                    end
`endif
                    else begin
                        w_err = 1'b1;
                    end
                end

                S_B: begin
                    if (w_is_digit) begin
                        if (r_cnt_b < 2'd2) begin
                            w_ad_b  = r_au_b;
                            w_au_b  = bus.char_in;
                            w_cnt_b = r_cnt_b + 2'd1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else if (bus.char_in == C_EQ) begin
                        if (r_cnt_b != 2'd0) begin
                            w_state = S_DONE;
                            w_valid = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
`ifdef BACKSPACE_EN
                    else if (bus.char_in == C_BS) begin
                        // Deleting past the first B digit steps back into A, which stays intact.
                        if (r_cnt_b != 2'd0) begin
                            w_au_b  = r_ad_b;
                            w_ad_b  = C_ZERO;
                            w_cnt_b = r_cnt_b - 2'd1;
                        end else begin
                            w_state = S_A;
                        end
                    end
`endif
                    else begin
                        w_err = 1'b1;
                    end
                end

                S_DONE: begin
                    // A digit here starts a new expression in the same edge.
                    if (w_is_digit) begin
                        w_ad_a  = C_ZERO;
                        w_au_a  = bus.char_in;
                        w_cnt_a = 2'd1;
                        w_ad_b  = C_ZERO;
                        w_au_b  = C_ZERO;
                        w_cnt_b = 2'd0;
                        w_err   = 1'b0;
                        w_state = S_A;
                    end
                end

                default: w_state = S_A;
            endcase
        end
    end

    assign bus.AD_A           = r_ad_a;
    assign bus.AU_A           = r_au_a;
    assign bus.AD_B           = r_ad_b;
    assign bus.AU_B           = r_au_b;
    assign bus.operands_valid = r_valid;
    assign bus.err            = r_err;
    assign bus.state          = r_state;
endmodule

// File: tb/tb_ascii_operand_capture.sv
// Randomized and directed bench for ascii_operand_capture against an operand-queue reference model.
// Honours BACKSPACE_EN the same way as the design build.
module tb_ascii_operand_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    ascii_operand_capture_if bus();

    ascii_operand_capture dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: each operand is the list of digits typed so far.
    logic [6:0] qa[$];
    logic [6:0] qb[$];
    int         m_phase;
    logic       m_err;
    logic       m_pulse;
`ifdef BACKSPACE_EN
    localparam bit BS_EN = 1'b1;
`else
    localparam bit BS_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] m_tens(input bit sel_b);
        if (sel_b) return (qb.size() == 2) ? qb[0] : 7'h30;
        return (qa.size() == 2) ? qa[0] : 7'h30;
    endfunction

    function automatic logic [6:0] m_units(input bit sel_b);
        if (sel_b) return (qb.size() >= 1) ? qb[qb.size()-1] : 7'h30;
        return (qa.size() >= 1) ? qa[qa.size()-1] : 7'h30;
    endfunction

    task automatic model_update(input logic v, input logic [6:0] c, input logic rn);
        bit is_digit;
        is_digit = (c >= 7'h30) && (c <= 7'h39);
        if (!rn) begin
            qa.delete(); qb.delete();
            m_phase = 0; m_err = 1'b0; m_pulse = 1'b0;
            return;
        end
        m_pulse = 1'b0;
        if (!v) return;
        case (m_phase)
            0: begin
                if (is_digit) begin
                    if (qa.size() < 2) qa.push_back(c); else m_err = 1'b1;
                end else if (c == 7'h2B) begin
                    if (qa.size() >= 1) m_phase = 1; else m_err = 1'b1;
                end else if (BS_EN && c == 7'h08) begin
                    if (qa.size() > 0) void'(qa.pop_back());
                end else m_err = 1'b1;
            end
            1: begin
                if (is_digit) begin
                    if (qb.size() < 2) qb.push_back(c); else m_err = 1'b1;
                end else if (c == 7'h3D) begin
                    if (qb.size() >= 1) begin m_phase = 2; m_pulse = 1'b1; end
                    else m_err = 1'b1;
                end else if (BS_EN && c == 7'h08) begin
                    if (qb.size() > 0) void'(qb.pop_back()); else m_phase = 0;
                end else m_err = 1'b1;
            end
            default: begin
                if (is_digit) begin
                    qa.delete(); qb.delete();
                    qa.push_back(c);
                    m_err = 1'b0;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        chk("AD_A", bus.AD_A, m_tens(1'b0));
        chk("AU_A", bus.AU_A, m_units(1'b0));
        chk("AD_B", bus.AD_B, m_tens(1'b1));
        chk("AU_B", bus.AU_B, m_units(1'b1));
        chk("operands_valid", bus.operands_valid, m_pulse);
        chk("err", bus.err, m_err);
        chk("state", bus.state, m_phase);
    endtask

    task automatic step(input logic v, input logic [6:0] c, input logic rn);
        @(negedge clk);
        bus.char_valid = v;
        bus.char_in    = c;
        rst_n          = rn;
        @(posedge clk);
        model_update(v, c, rn);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [6:0] c);
        step(1'b1, c, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 7'h00, 1'b0);
    endtask

    function automatic logic [6:0] rand_char();
        int r;
        r = $urandom_range(0, 99);
        if (r < 45) return 7'(7'h30 + $urandom_range(0, 9));
        if (r < 60) return 7'h2B;
        if (r < 75) return 7'h3D;
        if (r < 85) return 7'h08;
        return 7'($urandom_range(0, 127));
    endfunction

    initial begin
        int r;
        bus.char_valid = 1'b0;
        bus.char_in    = 7'h00;
        qa.delete(); qb.delete();
        m_phase = 0; m_err = 1'b0; m_pulse = 1'b0;

        do_reset();
        do_reset();
        chk("rst_state", bus.state, 2'd0);
        chk("rst_ad_a", bus.AD_A, 7'h30);

        // 47 + 05 =
        send("4"); send("7"); send("+"); send("0"); send("5"); send("=");
        chk("ex1_ad_a", bus.AD_A, 7'h34);
        chk("ex1_au_a", bus.AU_A, 7'h37);
        chk("ex1_ad_b", bus.AD_B, 7'h30);
        chk("ex1_au_b", bus.AU_B, 7'h35);
        chk("ex1_valid", bus.operands_valid, 1'b1);
        chk("ex1_state", bus.state, 2'd2);
        chk("ex1_err", bus.err, 1'b0);
        step(1'b0, "=", 1'b1);
        chk("ex1_valid_drop", bus.operands_valid, 1'b0);
        send("=");
        chk("done_ignore_err", bus.err, 1'b0);

        // 9 + 3 =, then restart on '6'
        do_reset();
        send("9"); send("+"); send("3"); send("=");
        chk("ex2_ad_a", bus.AD_A, 7'h30);
        chk("ex2_au_a", bus.AU_A, 7'h39);
        chk("ex2_au_b", bus.AU_B, 7'h33);
        send("6");
        chk("ex2_restart_au_a", bus.AU_A, 7'h36);
        chk("ex2_restart_au_b", bus.AU_B, 7'h30);
        chk("ex2_restart_state", bus.state, 2'd0);

        // third digit rejected, err sticky across '+'
        do_reset();
        send("1"); send("2"); send("3");
        chk("ex3_err", bus.err, 1'b1);
        chk("ex3_ad_a", bus.AD_A, 7'h31);
        chk("ex3_au_a", bus.AU_A, 7'h32);
        send("+");
        chk("ex3_state", bus.state, 2'd1);
        chk("ex3_err_sticky", bus.err, 1'b1);

        // error cases
        do_reset();
        send("+");
        chk("ex4_plus_err", bus.err, 1'b1);
        do_reset();
        send(7'h78);
        chk("ex4_inv_err", bus.err, 1'b1);
        do_reset();
        send("1"); send("+"); send("=");
        chk("ex4_eq_err", bus.err, 1'b1);
        chk("ex4_eq_novalid", bus.operands_valid, 1'b0);

        // backspace
        do_reset();
        send("5"); send("8"); send(7'h08);
`ifdef BACKSPACE_EN
        chk("ex5_ad_a", bus.AD_A, 7'h30);
        chk("ex5_au_a", bus.AU_A, 7'h35);
        chk("ex5_err", bus.err, 1'b0);
        send("+"); send(7'h08);
        chk("ex5_back_to_a", bus.state, 2'd0);
`else
        chk("ex5_ad_a", bus.AD_A, 7'h35);
        chk("ex5_au_a", bus.AU_A, 7'h38);
        chk("ex5_err", bus.err, 1'b1);
`endif

        // reset wins over a simultaneous character
        do_reset();
        send("1"); send("+"); send("2");
        step(1'b1, "7", 1'b0);
        chk("ex6_au_a", bus.AU_A, 7'h30);
        chk("ex6_au_b", bus.AU_B, 7'h30);
        chk("ex6_state", bus.state, 2'd0);
        chk("ex6_err", bus.err, 1'b0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       step(1'b1, rand_char(), 1'b0);
            else if (r < 12) step(1'b0, rand_char(), 1'b1);
            else             step(1'b1, rand_char(), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // operands_valid must never stay high for two consecutive cycles
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (prev_valid && bus.operands_valid)
            chk("valid_twice", bus.operands_valid, 1'b0);
        prev_valid <= bus.operands_valid;
    end
endmodule
